// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// Module   : ifetch
// Purpose  : R4 RV32I fetch stage. Issues word fetches over req/gnt/rvalid and
//            buffers responses in order for decode; redirect flushes everything.
//            Define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam int          CW    = $clog2(DEPTH + 1);
  localparam int          PW    = $clog2(DEPTH);
  localparam logic [CW:0] C_CAP = (CW + 1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_disc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [31:0]   r_buf_instr [DEPTH];
  logic [31:0]   r_buf_pc    [DEPTH];

  logic          w_gnt;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop_buf;
  logic          w_fault_hold;
  logic          w_fault_valid;
  logic [CW-1:0] w_live;
  logic [CW:0]   w_used;
  logic [31:0]   w_rsp_pc;
  logic [31:0]   w_redir_target;

  assign w_gnt          = imem_req & imem_gnt;
  assign w_rsp          = imem_rvalid & (r_out != '0);
  assign w_push         = w_rsp & (r_disc == '0) & ~redirect;
  assign w_pop_buf      = (r_count != '0) & instr_ready;
  assign w_redir_target = redirect_pc & 32'hFFFF_FFFC;

  // Non-dropped responses come from consecutive addresses ending just below
  // fetch_pc, so the oldest live one sits (outstanding - discard) words back.
  assign w_live   = r_out - r_disc;
  assign w_rsp_pc = r_fetch_pc - {{(30 - CW){1'b0}}, w_live, 2'b00};

  // A head leaving this cycle frees its slot, which keeps DEPTH=2 at 1 IPC.
  assign w_used   = {1'b0, r_count} + {1'b0, r_out} - {{CW{1'b0}}, w_pop_buf};
  assign imem_req  = rst_n & ~redirect & (w_used < C_CAP) & ~w_fault_hold;
  assign imem_addr = r_fetch_pc;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        r_fault_hold;
  logic        r_fault_valid;
  logic [31:0] r_fault_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_hold  <= 1'b0;
      r_fault_valid <= 1'b0;
      r_fault_pc    <= '0;
    end else if (redirect) begin
      r_fault_hold  <= |redirect_pc[1:0];
      r_fault_valid <= |redirect_pc[1:0];
      r_fault_pc    <= redirect_pc;
    end else if (r_fault_valid & instr_ready) begin
      r_fault_valid <= 1'b0;
    end
  end

  assign w_fault_hold  = r_fault_hold;
  assign w_fault_valid = r_fault_valid;
  assign misalign      = r_fault_valid;
  assign instr_pc      = r_fault_valid ? r_fault_pc : r_buf_pc[r_rd];
`else
  assign w_fault_hold  = 1'b0;
  assign w_fault_valid = 1'b0;
  assign instr_pc      = r_buf_pc[r_rd];
`endif

  assign instr_valid = (r_count != '0) | w_fault_valid;
  assign instr       = w_fault_valid ? 32'h0000_0000 : r_buf_instr[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_out      <= '0;
      r_disc     <= '0;
      r_count    <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_instr[i] <= '0;
        r_buf_pc[i]    <= '0;
      end
    end else if (redirect) begin
      // Everything already requested is now stale, including a response landing now.
      r_fetch_pc <= w_redir_target;
      r_out      <= r_out - CW'(w_rsp);
      r_disc     <= r_out - CW'(w_rsp);
      r_count    <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
    end else begin
      if (w_gnt) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      r_out <= r_out + CW'(w_gnt) - CW'(w_rsp);
      if (w_rsp && (r_disc != '0)) begin
        r_disc <= r_disc - CW'(1);
      end
      if (w_push) begin
        r_buf_instr[r_wr] <= imem_rdata;
        r_buf_pc[r_wr]    <= w_rsp_pc;
        r_wr              <= r_wr + PW'(1);
      end
      if (w_pop_buf) begin
        r_rd <= r_rd + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop_buf);
    end
  end

endmodule
`default_nettype wire
